fb_write_arbiter: RTL and testbench



---
 rtl/fb_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 79 +++++++
 rtl/fb_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_fb_write_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared types and helpers for the frame-buffer write arbiter.
//   calc_addr_w : byte-address width for a given display geometry
//   wr_state_e  : write FSM states (IDLE, WR1, WR2)
//   wr_req_t    : one write request {addr, data}; addr is sized for the
//                 largest supported frame buffer and narrowed by the user
// ---------------------------------------------------------------------------
package fb_pkg;

  // Widest RAM byte address any instance may use.
  localparam int REQ_ADDR_MAX_W = 32;

  function automatic int calc_addr_w(input int width, input int height, input int bpp);
    return $clog2(width * height * bpp);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR1  = 2'd1,
    WR2  = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [REQ_ADDR_MAX_W-1:0] addr;
    logic [7:0]                data;
  } wr_req_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO with an occupancy output.
// A push while full is accepted only when a pop happens at the same edge
// (the popped slot is reused), otherwise it is ignored; the owner decides
// whether that counts as an overflow.
//   clk_in, reset : clock, asynchronous active-high reset (pointers/level)
//   push_i        : write push_data_i at the next edge (if room)
//   pop_i         : discard the head entry at the next edge (if non-empty)
//   pop_data_o    : current head entry
//   full_o        : level == DEPTH
//   empty_o       : level == 0
//   level_o       : entries currently held
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o     = (level_q == LVL_W'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves at the same edge.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // DEPTH is a power of two, so the pointers wrap on overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read once the level covers them.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// ---------------------------------------------------------------------------
// fb_write_arbiter
// Shares the single frame-buffer RAM write port between two requesters.
// Port A (UART line loads) issues one-cycle strobes with no backpressure and
// is buffered in a small FIFO. Port B (fill/clear, scroll copy) is a
// valid/ready engine at lower priority, protected from starvation by a
// counter of consecutive A grants taken while B waits. Every grant becomes a
// two-cycle RAM write (states WR1, WR2); the next grant is decided in WR2 so
// back-to-back writes keep the enables continuously high.
//   clk_in, reset      : clock, asynchronous active-high reset
//   a_valid/addr/data  : port A write strobe
//   b_valid/addr/data  : port B request, b_ready accepts it (combinational)
//   ram_address        : registered RAM write address
//   ram_data_out       : registered RAM write data
//   ram_write_enable   : high during a write transaction
//   ram_clk_enable     : same as ram_write_enable
//   a_overflow         : sticky, a port A strobe was dropped
//   a_fifo_level       : port A entries buffered
//   busy               : write in progress or port A entries pending
// ---------------------------------------------------------------------------
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter  int PIXEL_WIDTH     = 64,
  parameter  int PIXEL_HEIGHT    = 32,
  parameter  int BYTES_PER_PIXEL = 2,
  parameter  int A_FIFO_DEPTH    = 4,
  parameter  int STARVE_LIMIT    = 3,
  localparam int ADDR_W          = calc_addr_w(PIXEL_WIDTH, PIXEL_HEIGHT, BYTES_PER_PIXEL),
  localparam int LVL_W           = $clog2(A_FIFO_DEPTH) + 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_data,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_data,
  output logic              b_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [7:0]        ram_data_out,
  output logic              ram_write_enable,
  output logic              ram_clk_enable,
  output logic              a_overflow,
  output logic [LVL_W-1:0]  a_fifo_level,
  output logic              busy
);

  localparam int          FIFO_W     = ADDR_W + 8;
  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

  wr_state_e         state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              ovf_q, ovf_d;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_head;

  logic              grant_pt;
  logic              a_win;
  logic              b_win;
  wr_req_t           a_req;
  wr_req_t           b_req;
  wr_req_t           win_req;
  logic              unused_addr_hi;

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (A_FIFO_DEPTH)
  ) u_a_fifo (
    .clk_in      (clk_in),
    .reset       (reset),
    .push_i      (a_valid),
    .push_data_i ({a_addr, a_data}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (a_fifo_level)
  );

  assign a_req.addr = REQ_ADDR_MAX_W'(fifo_head[FIFO_W-1:8]);
  assign a_req.data = fifo_head[7:0];
  assign b_req.addr = REQ_ADDR_MAX_W'(b_addr);
  assign b_req.data = b_data;

  // Upper request-address bits are zero-extension only.
  assign unused_addr_hi = ^win_req.addr[REQ_ADDR_MAX_W-1:ADDR_W];

  // Arbitration and FSM next state. A new write is granted from IDLE or from
  // the second cycle of the current write.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    data_d   = data_q;

    grant_pt = (state_q == IDLE) || (state_q == WR2);
    a_win    = grant_pt && !fifo_empty && (!b_valid || (starve_q < STARVE_MAX));
    b_win    = grant_pt && !a_win && b_valid;
    win_req  = a_win ? a_req : b_req;

    if (grant_pt) begin
      if (a_win || b_win) begin
        state_d = WR1;
        addr_d  = win_req.addr[ADDR_W-1:0];
        data_d  = win_req.data;
      end else begin
        state_d = IDLE;
      end
      // The guard only counts A grants taken while B is actually waiting.
      if (b_win || !b_valid) begin
        starve_d = '0;
      end else if (a_win && (starve_q < STARVE_MAX)) begin
        starve_d = starve_q + 4'd1;
      end
    end else begin
      state_d = WR2;
    end
  end

  // A strobe is lost only when the FIFO is full and nothing leaves this edge.
  assign ovf_d = ovf_q || (a_valid && fifo_full && !fifo_pop);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  assign fifo_pop         = a_win;
  assign b_ready          = b_win;
  assign ram_address      = addr_q;
  assign ram_data_out     = data_q;
  assign ram_write_enable = (state_q == WR1) || (state_q == WR2);
  assign ram_clk_enable   = (state_q == WR1) || (state_q == WR2);
  assign a_overflow       = ovf_q;
  assign busy             = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;

  localparam int AW = 12;

  logic          clk_in = 1'b0;
  logic          reset = 1'b1;
  logic          a_valid = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [7:0]    a_data = '0;
  logic          b_valid = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [7:0]    b_data = '0;
  logic          b_ready;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_data_out;
  logic          ram_write_enable;
  logic          ram_clk_enable;
  logic          a_overflow;
  logic [2:0]    a_fifo_level;
  logic          busy;

  fb_write_arbiter dut (
    .clk_in           (clk_in),
    .reset            (reset),
    .a_valid          (a_valid),
    .a_addr           (a_addr),
    .a_data           (a_data),
    .b_valid          (b_valid),
    .b_addr           (b_addr),
    .b_data           (b_data),
    .b_ready          (b_ready),
    .ram_address      (ram_address),
    .ram_data_out     (ram_data_out),
    .ram_write_enable (ram_write_enable),
    .ram_clk_enable   (ram_clk_enable),
    .a_overflow       (a_overflow),
    .a_fifo_level     (a_fifo_level),
    .busy             (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  int  total = 0;
  int  bad = 0;
  wr_t exp_a[$];
  wr_t exp_b[$];
  bit  grant_log[$];   // 0 = port A write, 1 = port B write
  int  n_writes = 0;
  int  wr_phase = 0;
  int  we_run = 0;
  int  we_run_last = 0;
  int  cyc = 0;
  wr_t mon_e;

  always @(posedge clk_in) cyc++;

  // Write monitor: every write is two enable-high cycles; the first cycle of
  // each is matched against the scoreboard. B traffic uses addresses >= 0x100.
  always @(negedge clk_in) begin
    if (reset) begin
      wr_phase = 0;
      we_run   = 0;
    end else begin
      total++;
      if (ram_clk_enable !== ram_write_enable) begin
        bad++;
        $display("FAIL en_match: clk_enable=%b write_enable=%b", ram_clk_enable, ram_write_enable);
      end
      if (ram_write_enable === 1'b1) begin
        we_run++;
        if (wr_phase == 0) begin
          n_writes++;
          total++;
          if (ram_address >= 12'h100) begin
            grant_log.push_back(1'b1);
            if (exp_b.size() == 0) begin
              bad++;
              $display("FAIL b_write: unexpected write addr=%h data=%h", ram_address, ram_data_out);
            end else begin
              mon_e = exp_b.pop_front();
              if ({ram_address, ram_data_out} !== {mon_e.addr, mon_e.data}) begin
                bad++;
                $display("FAIL b_write: got addr=%h data=%h want addr=%h data=%h",
                         ram_address, ram_data_out, mon_e.addr, mon_e.data);
              end
            end
          end else begin
            grant_log.push_back(1'b0);
            if (exp_a.size() == 0) begin
              bad++;
              $display("FAIL a_write: unexpected write addr=%h data=%h", ram_address, ram_data_out);
            end else begin
              mon_e = exp_a.pop_front();
              if ({ram_address, ram_data_out} !== {mon_e.addr, mon_e.data}) begin
                bad++;
                $display("FAIL a_write: got addr=%h data=%h want addr=%h data=%h",
                         ram_address, ram_data_out, mon_e.addr, mon_e.data);
              end
            end
          end
        end
        wr_phase = 1 - wr_phase;
      end else begin
        if (we_run != 0) we_run_last = we_run;
        we_run = 0;
        total++;
        if (wr_phase != 0) begin
          bad++;
          $display("FAIL write_len: enables dropped after 1 cycle, want 2");
        end
        wr_phase = 0;
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_in);
      if (busy === 1'b0 && exp_a.size() == 0 && exp_b.size() == 0) break;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    total++;
    if ({ram_write_enable, ram_clk_enable, b_ready, a_overflow, busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: we/ce/ready/ovf/busy=%b want 00000",
               {ram_write_enable, ram_clk_enable, b_ready, a_overflow, busy});
    end
    total++;
    if ({ram_address, ram_data_out, a_fifo_level} !== '0) begin
      bad++;
      $display("FAIL reset_data: addr=%h data=%h level=%0d want 0", ram_address, ram_data_out, a_fifo_level);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_single_a();
    int w0;
    w0 = n_writes;
    @(negedge clk_in);
    a_valid = 1'b1; a_addr = 12'h07F; a_data = 8'hA5;
    exp_a.push_back('{addr: 12'h07F, data: 8'hA5});
    @(negedge clk_in);
    a_valid = 1'b0;
    total++;
    if ({ram_write_enable, a_fifo_level, busy} !== {1'b0, 3'd1, 1'b1}) begin
      bad++;
      $display("FAIL single_e0: we=%b level=%0d busy=%b want 0 1 1", ram_write_enable, a_fifo_level, busy);
    end
    @(negedge clk_in);
    total++;
    if ({ram_write_enable, a_fifo_level, ram_address, ram_data_out} !== {1'b1, 3'd0, 12'h07F, 8'hA5}) begin
      bad++;
      $display("FAIL single_e1: we=%b level=%0d addr=%h data=%h want 1 0 07f a5",
               ram_write_enable, a_fifo_level, ram_address, ram_data_out);
    end
    @(negedge clk_in);
    total++;
    if (ram_write_enable !== 1'b1) begin
      bad++;
      $display("FAIL single_e2: we=%b want 1", ram_write_enable);
    end
    @(negedge clk_in);
    total++;
    if ({ram_write_enable, busy} !== 2'b00) begin
      bad++;
      $display("FAIL single_e3: we=%b busy=%b want 0 0", ram_write_enable, busy);
    end
    wait_idle();
    total++;
    if (we_run_last !== 2 || n_writes - w0 !== 1) begin
      bad++;
      $display("FAIL single_len: run=%0d writes=%0d want 2 1", we_run_last, n_writes - w0);
    end
  endtask

  // Strobes every cycle: the FIFO gains one entry per 2-cycle write, fills
  // after the 7th strobe, and the 8th lands on a pop edge while full.
  task automatic test_push_pop_full();
    int w0, lvl;
    w0 = n_writes;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk_in);
      if (i > 0) begin
        lvl = (i - 1) / 2 + 1;
        if (lvl > 4) lvl = 4;
        total++;
        if (a_fifo_level !== 3'(lvl)) begin
          bad++;
          $display("FAIL ppf_level[%0d]: got %0d want %0d", i - 1, a_fifo_level, lvl);
        end
      end
      if (i < 8) begin
        a_valid = 1'b1; a_addr = 12'h040 + 12'(i); a_data = 8'h30 + 8'(i);
        exp_a.push_back('{addr: 12'h040 + 12'(i), data: 8'h30 + 8'(i)});
      end else begin
        a_valid = 1'b0;
      end
    end
    total++;
    if (a_overflow !== 1'b0) begin
      bad++;
      $display("FAIL ppf_ovf: got %b want 0", a_overflow);
    end
    wait_idle();
    total++;
    if (n_writes - w0 !== 8 || exp_a.size() != 0 || a_overflow !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ppf_drain: writes=%0d left=%0d ovf=%b busy=%b want 8 0 0 0",
               n_writes - w0, exp_a.size(), a_overflow, busy);
    end
  endtask

  task automatic test_overflow();
    int w0, lvl;
    w0 = n_writes;
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk_in);
      if (i > 0) begin
        lvl = (i - 1) / 2 + 1;
        if (lvl > 4) lvl = 4;
        total++;
        if (a_fifo_level !== 3'(lvl) || a_overflow !== (i - 1 >= 8)) begin
          bad++;
          $display("FAIL ovf_step[%0d]: level=%0d ovf=%b want %0d %b",
                   i - 1, a_fifo_level, a_overflow, lvl, (i - 1 >= 8));
        end
      end
      if (i < 9) begin
        a_valid = 1'b1; a_addr = 12'h060 + 12'(i); a_data = 8'h50 + 8'(i);
        if (i < 8) exp_a.push_back('{addr: 12'h060 + 12'(i), data: 8'h50 + 8'(i)});
      end else begin
        a_valid = 1'b0;
      end
    end
    wait_idle();
    total++;
    if (n_writes - w0 !== 8 || exp_a.size() != 0 || a_overflow !== 1'b1 || a_fifo_level !== 3'd0) begin
      bad++;
      $display("FAIL ovf_drain: writes=%0d left=%0d ovf=%b level=%0d want 8 0 1 0",
               n_writes - w0, exp_a.size(), a_overflow, a_fifo_level);
    end
  endtask

  task automatic test_reset_mid_write();
    int w0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      a_valid = 1'b1; a_addr = 12'h020 + 12'(i); a_data = 8'h90 + 8'(i);
      exp_a.push_back('{addr: 12'h020 + 12'(i), data: 8'h90 + 8'(i)});
    end
    @(negedge clk_in);
    a_valid = 1'b0;
    total++;
    if ({ram_write_enable, a_fifo_level} !== {1'b1, 3'd2}) begin
      bad++;
      $display("FAIL rmw_pre: we=%b level=%0d want 1 2", ram_write_enable, a_fifo_level);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({ram_write_enable, ram_clk_enable, busy, a_fifo_level, ram_address} !== '0) begin
      bad++;
      $display("FAIL rmw_abort: we=%b ce=%b busy=%b level=%0d addr=%h want all 0",
               ram_write_enable, ram_clk_enable, busy, a_fifo_level, ram_address);
    end
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    exp_a.delete();
    exp_b.delete();
    w0 = n_writes;
    repeat (10) @(negedge clk_in);
    total++;
    if (n_writes !== w0 || ram_write_enable !== 1'b0 || a_overflow !== 1'b0) begin
      bad++;
      $display("FAIL rmw_after: writes=%0d we=%b ovf=%b want 0 0 0", n_writes - w0, ram_write_enable, a_overflow);
    end
  endtask

  task automatic test_b_stream();
    int hs;
    int hs_cyc[4];
    hs = 0;
    @(negedge clk_in);
    b_valid = 1'b1; b_addr = 12'h100; b_data = 8'h10;
    #1;
    for (int k = 0; k < 40 && hs < 4; k++) begin
      if (b_ready === 1'b1) begin
        exp_b.push_back('{addr: b_addr, data: b_data});
        hs_cyc[hs] = cyc;
        hs++;
        @(posedge clk_in);
        #1;
        if (hs == 4) b_valid = 1'b0;
        else begin
          b_addr = 12'h100 + 12'(hs);
          b_data = 8'h10 + 8'(hs);
        end
      end
      @(negedge clk_in);
    end
    total++;
    if (hs !== 4) begin
      bad++;
      $display("FAIL bs_count: handshakes=%0d want 4", hs);
    end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (hs_cyc[i] - hs_cyc[i - 1] !== 2) begin
        bad++;
        $display("FAIL bs_spacing[%0d]: got %0d cycles want 2", i, hs_cyc[i] - hs_cyc[i - 1]);
      end
    end
    wait_idle();
    total++;
    if (we_run_last !== 8 || exp_b.size() != 0) begin
      bad++;
      $display("FAIL bs_run: enable run=%0d left=%0d want 8 0", we_run_last, exp_b.size());
    end
  endtask

  task automatic test_contention();
    int hs;
    hs = 0;
    grant_log.delete();
    @(negedge clk_in);
    a_valid = 1'b1; a_addr = 12'h000; a_data = 8'hE0;
    exp_a.push_back('{addr: 12'h000, data: 8'hE0});
    fork
      begin
        for (int i = 1; i < 12; i++) begin
          @(negedge clk_in);
          a_valid = 1'b0;
          @(negedge clk_in);
          a_valid = 1'b1; a_addr = 12'(i); a_data = 8'hE0 + 8'(i);
          exp_a.push_back('{addr: 12'(i), data: 8'hE0 + 8'(i)});
        end
        @(negedge clk_in);
        a_valid = 1'b0;
      end
      begin
        @(negedge clk_in);
        b_valid = 1'b1; b_addr = 12'h180; b_data = 8'h70;
        for (int k = 0; k < 100 && hs < 3; k++) begin
          @(negedge clk_in);
          if (b_ready === 1'b1) begin
            exp_b.push_back('{addr: b_addr, data: b_data});
            hs++;
            @(posedge clk_in);
            #1;
            if (hs == 3) b_valid = 1'b0;
            else begin
              b_addr = 12'h180 + 12'(hs);
              b_data = 8'h70 + 8'(hs);
            end
          end
        end
      end
    join
    wait_idle();
    total++;
    if (hs !== 3 || grant_log.size() !== 15) begin
      bad++;
      $display("FAIL cont_count: b handshakes=%0d writes=%0d want 3 15", hs, grant_log.size());
    end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (grant_log[i] !== (i % 4 == 3)) begin
        bad++;
        $display("FAIL cont_grant[%0d]: got %s want %s", i,
                 grant_log[i] ? "B" : "A", (i % 4 == 3) ? "B" : "A");
      end
    end
    total++;
    if (exp_a.size() != 0 || exp_b.size() != 0 || a_overflow !== 1'b0) begin
      bad++;
      $display("FAIL cont_drain: left a=%0d b=%0d ovf=%b want 0 0 0", exp_a.size(), exp_b.size(), a_overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_push_pop_full();
    test_overflow();
    test_reset_mid_write();
    test_b_stream();
    test_contention();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
